// File: rtl/audio_pkg.sv
// Shared types for the serial audio receive path: default word width,
// sample type and the receiver FSM encoding.
package audio_pkg;

  localparam int AUDIO_SAMPLE_BITS = 16;

  typedef logic [AUDIO_SAMPLE_BITS-1:0] sample_t;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } rx_state_t;

  // Channel that a word-select level selects: 0 = left, 1 = right.
  function automatic rx_state_t chan_state(input logic ws);
    return ws ? RIGHT : LEFT;
  endfunction

endpackage

// File: rtl/dac_serial_rx_sync_edge.sv
// Multi-flop synchroniser for an asynchronous line with rise/fall strobes
// on the synchronised level.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // No reset: prev always tracks the synced level, so reset never
  // manufactures an edge from a line that is already high.
  always_ff @(posedge clk) begin
    chain <= {chain[STAGES-2:0], d};
    prev  <= chain[STAGES-1];
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/dac_serial_rx.sv
// Receive end of the serial DAC link: oversamples bck/ws/data, deserialises
// MSB-first words and presents left/right pairs on a valid/ready handshake.
module dac_serial_rx
  import audio_pkg::*;
#(
  parameter int SAMPLE_BITS = AUDIO_SAMPLE_BITS,
  parameter bit I2S_DELAY   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   tg42,
  input  logic                   reset,
  input  logic                   dac_bck,
  input  logic                   dac_ws,
  input  logic                   dac_data,
  output logic [SAMPLE_BITS-1:0] out_left,
  output logic [SAMPLE_BITS-1:0] out_right,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   overrun,
  output logic                   short_word,
  input  logic                   clr_flags,
  output rx_state_t              state
);

  // Handshake: a pair transfers on any cycle with out_valid && out_ready;
  // out_valid holds with stable data until then, except that a newer pair
  // overwrites an unaccepted one (flagged by overrun).

  localparam int CW = $clog2(SAMPLE_BITS + 1);
  localparam logic [CW-1:0] FULL = CW'(SAMPLE_BITS);

  logic bck_s, bck_rise, bck_fall;
  logic ws_s, ws_rise, ws_fall;
  logic [SYNC_STAGES-1:0] data_chain;
  logic data_s;
  logic unused_sync;

  sync_edge #(.STAGES(SYNC_STAGES)) u_bck_sync (
    .clk   (tg42),
    .d     (dac_bck),
    .level (bck_s),
    .rise  (bck_rise),
    .fall  (bck_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_ws_sync (
    .clk   (tg42),
    .d     (dac_ws),
    .level (ws_s),
    .rise  (ws_rise),
    .fall  (ws_fall)
  );

  // Same depth as the bck/ws chains so all three lines stay time-aligned.
  always_ff @(posedge tg42) begin
    data_chain <= {data_chain[SYNC_STAGES-2:0], dac_data};
  end

  assign data_s      = data_chain[SYNC_STAGES-1];
  assign unused_sync = ^{bck_s, bck_fall, ws_rise, ws_fall};

  logic                   ws_d1, ws_d2;
  logic [1:0]             seen;
  logic                   eff_ws, eff_prev, eff_ok, eff_change;
  rx_state_t              state_next;
  logic                   word_end;
  logic [SAMPLE_BITS-1:0] shreg;
  logic [CW-1:0]          bitcnt;
  logic [CW-1:0]          shamt;
  logic                   is_short;
  logic [SAMPLE_BITS-1:0] word_aligned;
  logic [SAMPLE_BITS-1:0] hold_left;
  logic                   have_left;
  logic                   left_done, pair_done;

  // Effective word select: under I2S the channel switch lags the ws edge
  // by one bck, because that first bit is the previous word's LSB.
  always_comb begin
    eff_ws   = ws_s;
    eff_prev = ws_d1;
    eff_ok   = (seen != 2'd0);
    if (I2S_DELAY) begin
      eff_ws   = ws_d1;
      eff_prev = ws_d2;
      eff_ok   = seen[1];
    end
  end

  assign eff_change = bck_rise && eff_ok && (eff_ws != eff_prev);

  always_ff @(posedge tg42) begin
    if (reset) state <= SYNC;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    word_end   = 1'b0;
    case (state)
      SYNC: begin
        if (eff_change) state_next = chan_state(eff_ws);
      end
      LEFT, RIGHT: begin
        if (eff_change) begin
          word_end   = 1'b1;
          state_next = chan_state(eff_ws);
        end
      end
      default: state_next = SYNC;
    endcase
  end

  assign is_short     = (bitcnt < FULL);
  assign shamt        = FULL - bitcnt;
  assign word_aligned = is_short ? (shreg << shamt) : shreg;
  assign left_done    = word_end && (state == LEFT);
  assign pair_done    = word_end && (state == RIGHT) && have_left;

  always_ff @(posedge tg42) begin
    if (reset) begin
      ws_d1      <= 1'b0;
      ws_d2      <= 1'b0;
      seen       <= 2'd0;
      shreg      <= '0;
      bitcnt     <= '0;
      hold_left  <= '0;
      have_left  <= 1'b0;
      out_left   <= '0;
      out_right  <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
      short_word <= 1'b0;
    end else begin
      if (bck_rise) begin
        ws_d1 <= ws_s;
        ws_d2 <= ws_d1;
        if (seen != 2'd3) seen <= seen + 2'd1;
        // The bit on the effective change is the MSB of the new word.
        if (eff_change) begin
          shreg  <= {{(SAMPLE_BITS-1){1'b0}}, data_s};
          bitcnt <= CW'(1);
        end else if ((state != SYNC) && is_short) begin
          shreg  <= {shreg[SAMPLE_BITS-2:0], data_s};
          bitcnt <= bitcnt + CW'(1);
        end
      end

      if (left_done) begin
        hold_left <= word_aligned;
        have_left <= 1'b1;
      end

      if (pair_done) begin
        out_left  <= hold_left;
        out_right <= word_aligned;
        have_left <= 1'b0;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (pair_done && out_valid && !out_ready) overrun <= 1'b1;
      else if (clr_flags)                       overrun <= 1'b0;

      if (word_end && is_short) short_word <= 1'b1;
      else if (clr_flags)       short_word <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dac_serial_rx.sv
// Directed bench for dac_serial_rx: I2S and left-justified frames, truncation,
// zero padding, flags, overrun and mid-word reset.
module tb_dac_serial_rx;
  import audio_pkg::*;

  logic tg42 = 1'b0;
  logic reset, dac_bck, dac_ws, dac_data, out_ready, clr_flags;

  logic [15:0] out_left_a, out_right_a, out_left_b, out_right_b;
  logic        out_valid_a, overrun_a, short_word_a;
  logic        out_valid_b, overrun_b, short_word_b;
  rx_state_t   state_a, state_b;

  int checks   = 0;
  int failures = 0;

  // clock/reset block
  always #5 tg42 = ~tg42;

  dac_serial_rx #(.SAMPLE_BITS(16), .I2S_DELAY(1'b1), .SYNC_STAGES(2)) dut (
    .tg42(tg42), .reset(reset), .dac_bck(dac_bck), .dac_ws(dac_ws), .dac_data(dac_data),
    .out_left(out_left_a), .out_right(out_right_a), .out_valid(out_valid_a),
    .out_ready(out_ready), .overrun(overrun_a), .short_word(short_word_a),
    .clr_flags(clr_flags), .state(state_a)
  );

  dac_serial_rx #(.SAMPLE_BITS(16), .I2S_DELAY(1'b0), .SYNC_STAGES(2)) dut_lj (
    .tg42(tg42), .reset(reset), .dac_bck(dac_bck), .dac_ws(dac_ws), .dac_data(dac_data),
    .out_left(out_left_b), .out_right(out_right_b), .out_valid(out_valid_b),
    .out_ready(out_ready), .overrun(overrun_b), .short_word(short_word_b),
    .clr_flags(clr_flags), .state(state_b)
  );

  // Accept monitor: counts transfers, remembers the last accepted pair and
  // counts back-to-back accepts (a valid pulse longer than one cycle).
  int          acc_a = 0, acc_b = 0, dbl_a = 0, dbl_b = 0;
  logic [15:0] acc_left_a = '0, acc_right_a = '0, acc_left_b = '0, acc_right_b = '0;
  logic        prev_acc_a = 1'b0, prev_acc_b = 1'b0;

  always @(negedge tg42) begin
    if (out_valid_a && out_ready) begin
      acc_a++;
      acc_left_a  = out_left_a;
      acc_right_a = out_right_a;
      if (prev_acc_a) dbl_a++;
    end
    prev_acc_a = out_valid_a && out_ready;
    if (out_valid_b && out_ready) begin
      acc_b++;
      acc_left_b  = out_left_b;
      acc_right_b = out_right_b;
      if (prev_acc_b) dbl_b++;
    end
    prev_acc_b = out_valid_b && out_ready;
  end

  // driver tasks
  task automatic tick();
    @(posedge tg42);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
  endtask

  // One bck period of 8 tg42 cycles; data and ws change while bck is low.
  task automatic send_bit(input logic ws, input logic b);
    dac_bck  = 1'b0;
    dac_ws   = ws;
    dac_data = b;
    repeat (4) tick();
    dac_bck = 1'b1;
    repeat (4) tick();
  endtask

  // Sends bits n-1..0 of w; with i2s set the LSB already carries the next ws.
  task automatic send_word(input logic chan, input logic [23:0] w, input int n, input bit i2s);
    for (int i = n - 1; i >= 0; i--) begin
      send_bit((i2s && i == 0) ? ~chan : chan, w[i]);
    end
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int n, input bit i2s);
    send_word(1'b0, l, n, i2s);
    send_word(1'b1, r, n, i2s);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int acc0, dbl0;

  initial begin
    reset = 1'b1; dac_bck = 1'b0; dac_ws = 1'b0; dac_data = 1'b0;
    out_ready = 1'b1; clr_flags = 1'b0;
    repeat (4) tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_left",  out_left_a, 16'h0000);
    chk("rst_right", out_right_a, 16'h0000);
    chk("rst_valid", out_valid_a, 1'b0);
    chk("rst_ovr",   overrun_a, 1'b0);
    chk("rst_short", short_word_a, 1'b0);
    chk("rst_state", 32'(state_a), 32'(SYNC));

    // Case 1: I2S 16-bit frames, ready held high
    acc0 = acc_a; dbl0 = dbl_a;
    repeat (4) send_frame(24'hA5C3, 24'h1234, 16, 1'b1);
    repeat (4) tick();
    chk("i2s_pairs",  32'(acc_a - acc0), 32'd2);
    chk("i2s_left",   acc_left_a, 16'hA5C3);
    chk("i2s_right",  acc_right_a, 16'h1234);
    chk("i2s_pulse",  32'(dbl_a - dbl0), 32'd0);
    chk("i2s_valid",  out_valid_a, 1'b0);
    chk("i2s_short",  short_word_a, 1'b0);

    // Case 2: start mid right word, 5-bit tail discarded
    do_reset();
    acc0 = acc_a;
    send_word(1'b1, 24'h16, 5, 1'b1);
    send_frame(24'h0F0F, 24'hF0F0, 16, 1'b1);
    send_frame(24'h5A5A, 24'hC3C3, 16, 1'b1);
    repeat (4) tick();
    chk("mid_pairs", 32'(acc_a - acc0), 32'd1);
    chk("mid_left",  acc_left_a, 16'h0F0F);
    chk("mid_right", acc_right_a, 16'hF0F0);
    chk("mid_short", short_word_a, 1'b0);

    // Case 3: 24-bit words truncate to the top 16 bits
    do_reset();
    acc0 = acc_a;
    repeat (3) send_frame(24'h80FF01, 24'h7FFFFF, 24, 1'b1);
    repeat (4) tick();
    chk("w24_pairs", 32'(acc_a - acc0), 32'd1);
    chk("w24_left",  acc_left_a, 16'h80FF);
    chk("w24_right", acc_right_a, 16'h7FFF);
    chk("w24_short", short_word_a, 1'b0);

    // Case 4: 12-bit words are zero padded and flagged; clr_flags clears
    do_reset();
    acc0 = acc_a;
    repeat (3) send_frame(24'hABC, 24'h123, 12, 1'b1);
    repeat (4) tick();
    chk("w12_pairs", 32'(acc_a - acc0), 32'd1);
    chk("w12_left",  acc_left_a, 16'hABC0);
    chk("w12_right", acc_right_a, 16'h1230);
    chk("w12_short", short_word_a, 1'b1);
    chk("w12_ovr",   overrun_a, 1'b0);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    tick();
    chk("w12_clr", short_word_a, 1'b0);

    // Case 5: consumer stalled across two pairs
    out_ready = 1'b0;
    do_reset();
    acc0 = acc_a;
    send_frame(24'h1111, 24'h2222, 16, 1'b1);
    send_frame(24'h1111, 24'h2222, 16, 1'b1);
    send_frame(24'h3333, 24'h4444, 16, 1'b1);
    chk("ovr_valid1", out_valid_a, 1'b1);
    chk("ovr_left1",  out_left_a, 16'h1111);
    chk("ovr_right1", out_right_a, 16'h2222);
    chk("ovr_flag1",  overrun_a, 1'b0);
    send_frame(24'h5555, 24'h6666, 16, 1'b1);
    chk("ovr_valid2", out_valid_a, 1'b1);
    chk("ovr_left2",  out_left_a, 16'h3333);
    chk("ovr_right2", out_right_a, 16'h4444);
    chk("ovr_flag2",  overrun_a, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("ovr_drop",   out_valid_a, 1'b0);
    chk("ovr_acc",    32'(acc_a - acc0), 32'd1);
    chk("ovr_accl",   acc_left_a, 16'h3333);
    chk("ovr_sticky", overrun_a, 1'b1);
    out_ready = 1'b1;

    // Case 6: reset in the middle of a right word, then resume
    do_reset();
    repeat (3) send_frame(24'hA5C3, 24'h1234, 16, 1'b1);
    send_word(1'b0, 24'hA5C3, 16, 1'b1);
    for (int i = 15; i >= 10; i--) send_bit(1'b1, 1'(16'h1234 >> i));
    reset = 1'b1;
    repeat (3) tick();
    chk("mrst_left",  out_left_a, 16'h0000);
    chk("mrst_right", out_right_a, 16'h0000);
    chk("mrst_valid", out_valid_a, 1'b0);
    chk("mrst_ovr",   overrun_a, 1'b0);
    chk("mrst_state", 32'(state_a), 32'(SYNC));
    reset = 1'b0;
    acc0 = acc_a;
    send_word(1'b1, 24'h1234, 10, 1'b1);
    chk("mrst_sync", 32'(state_a), 32'(SYNC));
    send_frame(24'h5A5A, 24'hC3C3, 16, 1'b1);
    send_frame(24'h5A5A, 24'hC3C3, 16, 1'b1);
    repeat (4) tick();
    chk("mrst_pairs", 32'(acc_a - acc0), 32'd1);
    chk("mrst_leftv", acc_left_a, 16'h5A5A);
    chk("mrst_rightv", acc_right_a, 16'hC3C3);
    chk("mrst_short", short_word_a, 1'b0);

    // Case 1 again on the left-justified receiver
    do_reset();
    acc0 = acc_b; dbl0 = dbl_b;
    chk("lj_rst_state", 32'(state_b), 32'(SYNC));
    repeat (4) send_frame(24'hA5C3, 24'h1234, 16, 1'b0);
    repeat (4) tick();
    chk("lj_pairs", 32'(acc_b - acc0), 32'd2);
    chk("lj_left",  acc_left_b, 16'hA5C3);
    chk("lj_right", acc_right_b, 16'h1234);
    chk("lj_pulse", 32'(dbl_b - dbl0), 32'd0);
    chk("lj_short", short_word_b, 1'b0);
    chk("lj_ovr",   overrun_b, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
